// File: rtl/scan_decoder_if.sv
// -----------------------------------------------------------------------------
// scan_decoder_if
//   Bundles the control inputs and decoded outputs of scan_decoder so the
//   decoder can be dropped into a design as a single port.
//
//   Signals
//     en      : global enable; low forces every output line to 0
//     mode    : 0 = direct decode of sel, 1 = autonomous scan
//     sel     : line select used in direct mode
//     dwell   : scan slot length minus one, in clk cycles
//     onehot  : registered decoded lines, at most one high
//     idx     : index of the current or last driven line
//     wrap    : one-cycle pulse when the scan returns from the last line to 0
//
//   Modports
//     master  : drives en/mode/sel/dwell, observes the outputs
//     slave   : the decoder side
// -----------------------------------------------------------------------------
interface scan_decoder_if #(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 8
);
   localparam int LINES = 1 << SEL_W;

   logic               en;
   logic               mode;
   logic [SEL_W-1:0]   sel;
   logic [DWELL_W-1:0] dwell;
   logic [LINES-1:0]   onehot;
   logic [SEL_W-1:0]   idx;
   logic               wrap;

   modport master (
      output en, mode, sel, dwell,
      input  onehot, idx, wrap
   );

   modport slave (
      input  en, mode, sel, dwell,
      output onehot, idx, wrap
   );
endinterface : scan_decoder_if

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//   Registered 1-of-2^SEL_W decoder with enable and two modes:
//     direct : onehot follows sel with exactly one cycle of latency
//     scan   : a single high line steps through all lines, each slot lasting
//              dwell+1 cycles; with BBM=1 an all-zero cycle separates slots
//   Used for display digit enables, keypad row strobes and chip-select fan-out.
//
//   Parameters
//     SEL_W   : select width, 2^SEL_W output lines (1 is legal)
//     DWELL_W : width of dwell and of the slot counter
//     BBM     : 1 = break-before-make blanking between scan slots
//
//   Ports
//     clk     : rising-edge clock
//     rst     : asynchronous, active-high reset
//     bus     : scan_decoder_if.slave (en, mode, sel, dwell in;
//               onehot, idx, wrap out)
//
//   Every output comes straight from a flop; no input reaches an output
//   without passing through a clock edge.
// -----------------------------------------------------------------------------
module scan_decoder #(
   parameter int SEL_W   = 2,
   parameter int DWELL_W = 8,
   parameter int BBM     = 0
) (
   input  logic          clk,
   input  logic          rst,
   scan_decoder_if.slave bus
);

   localparam int               LINES = 1 << SEL_W;
   localparam logic [SEL_W-1:0] LAST  = '1;   // index of line 2^SEL_W-1

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIRECT,
      S_SCAN,
      S_GAP
   } state_t;

   state_t             r_state;
   logic [DWELL_W-1:0] r_cnt;
   logic [LINES-1:0]   r_onehot;
   logic [SEL_W-1:0]   r_idx;
   logic               r_wrap;

   logic [SEL_W-1:0]   w_next_idx;
   logic [LINES-1:0]   w_next_oh;
   logic [LINES-1:0]   w_sel_oh;
   logic               w_at_last;

   // Next scan line: the all-ones index rolls over to 0 naturally.
   assign w_at_last  = (r_idx == LAST);
   assign w_next_idx = w_at_last ? '0 : r_idx + 1'b1;
   assign w_next_oh  = LINES'(1) << w_next_idx;
   assign w_sel_oh   = LINES'(1) << bus.sel;

   // Single-process state machine; all outputs are registered here.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_onehot <= '0;
         r_idx    <= '0;
         r_wrap   <= 1'b0;
      end else begin
         // wrap is a pulse: cleared every cycle unless a slot step sets it
         // below (the later non-blocking assignment wins).
         r_wrap <= 1'b0;

         if (!bus.en) begin
            // idx deliberately holds so software can see the last line.
            r_state  <= S_IDLE;
            r_onehot <= '0;
            r_cnt    <= '0;
         end else if (!bus.mode) begin
            // Direct mode from any state, including a scan in progress.
            r_state  <= S_DIRECT;
            r_onehot <= w_sel_oh;
            r_idx    <= bus.sel;
            r_cnt    <= '0;
         end else begin
            case (r_state)
               S_IDLE, S_DIRECT: begin
                  // Scan entry always restarts at line 0 with a fresh slot.
                  r_state  <= S_SCAN;
                  r_idx    <= '0;
                  r_onehot <= LINES'(1);
                  r_cnt    <= bus.dwell;
               end

               S_SCAN: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - 1'b1;
                  end else if (BBM != 0) begin
                     // Blank one cycle; idx keeps pointing at the old line.
                     r_state  <= S_GAP;
                     r_onehot <= '0;
                  end else begin
                     // dwell is sampled only here, so mid-slot changes
                     // affect the next slot, never the current one.
                     r_idx    <= w_next_idx;
                     r_onehot <= w_next_oh;
                     r_cnt    <= bus.dwell;
                     r_wrap   <= w_at_last;
                  end
               end

               S_GAP: begin
                  r_state  <= S_SCAN;
                  r_idx    <= w_next_idx;
                  r_onehot <= w_next_oh;
                  r_cnt    <= bus.dwell;
                  r_wrap   <= w_at_last;
               end

               default: begin
                  r_state  <= S_IDLE;
                  r_onehot <= '0;
                  r_cnt    <= '0;
               end
            endcase
         end
      end
   end

   assign bus.onehot = r_onehot;
   assign bus.idx    = r_idx;
   assign bus.wrap   = r_wrap;

   // Structural invariants of the decoded output.
   a_never_multi_hot : assert property (
      @(posedge clk) disable iff (rst) $countones(r_onehot) <= 1
   );

   a_wrap_on_line0 : assert property (
      @(posedge clk) disable iff (rst) r_wrap |-> (r_onehot == LINES'(1))
   );

endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//   Three decoders share one stimulus stream:
//     u0 : SEL_W=2, BBM=0
//     u1 : SEL_W=2, BBM=1
//     u2 : SEL_W=1, BBM=0
//   A slot-based reference model (slot age versus slot length captured at slot
//   start) predicts every output; a compare process checks all instances on
//   each falling edge. Directed sections add hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       en    = 1'b0;
   logic       mode  = 1'b0;
   logic [1:0] sel   = '0;
   logic [7:0] dwell = '0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   scan_decoder_if #(.SEL_W(2), .DWELL_W(8)) if0 ();
   scan_decoder_if #(.SEL_W(2), .DWELL_W(8)) if1 ();
   scan_decoder_if #(.SEL_W(1), .DWELL_W(8)) if2 ();

   assign if0.en = en;  assign if0.mode = mode;  assign if0.sel = sel;     assign if0.dwell = dwell;
   assign if1.en = en;  assign if1.mode = mode;  assign if1.sel = sel;     assign if1.dwell = dwell;
   assign if2.en = en;  assign if2.mode = mode;  assign if2.sel = sel[0];  assign if2.dwell = dwell;

   scan_decoder #(.SEL_W(2), .DWELL_W(8), .BBM(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
   scan_decoder #(.SEL_W(2), .DWELL_W(8), .BBM(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
   scan_decoder #(.SEL_W(1), .DWELL_W(8), .BBM(0)) u2 (.clk(clk), .rst(rst), .bus(if2));

   logic [3:0] act_oh   [3];
   logic [1:0] act_idx  [3];
   logic       act_wrap [3];

   assign act_oh[0] = if0.onehot;          assign act_idx[0] = if0.idx;          assign act_wrap[0] = if0.wrap;
   assign act_oh[1] = if1.onehot;          assign act_idx[1] = if1.idx;          assign act_wrap[1] = if1.wrap;
   assign act_oh[2] = {2'b00, if2.onehot}; assign act_idx[2] = {1'b0, if2.idx};  assign act_wrap[2] = if2.wrap;

   // ---------------------------------------------------------------- model
   typedef enum logic [1:0] {K_OFF, K_DIRECT, K_SCAN} kind_t;

   typedef struct packed {
      kind_t      kind;
      logic [1:0] line;    // line currently (or last) driven
      logic [8:0] age;     // cycles already spent in this slot, minus one
      logic [8:0] len;     // slot length captured when the slot started
      logic       gap;     // inside the blank cycle between slots
      logic [3:0] onehot;
      logic       wrap;
   } mstate_t;

   mstate_t m [3];

   function automatic int lines_of(int k);
      return (k == 2) ? 2 : 4;
   endfunction

   function automatic bit bbm_of(int k);
      return (k == 1);
   endfunction

   function automatic mstate_t model_step(mstate_t s, int k, logic en_i, logic mode_i,
                                          logic [1:0] sel_i, logic [7:0] dw_i);
      mstate_t r;
      int      n;
      int      nxt;
      n      = lines_of(k);
      r      = s;
      r.wrap = 1'b0;
      if (!en_i) begin
         r.kind   = K_OFF;
         r.onehot = '0;
      end else if (!mode_i) begin
         r.kind   = K_DIRECT;
         r.line   = 2'(int'(sel_i) % n);
         r.onehot = 4'(1 << (int'(sel_i) % n));
      end else if (s.kind != K_SCAN) begin
         r.kind   = K_SCAN;
         r.line   = 2'd0;
         r.onehot = 4'b0001;
         r.age    = 9'd0;
         r.len    = {1'b0, dw_i} + 9'd1;
         r.gap    = 1'b0;
      end else if (!s.gap && (s.age + 9'd1 < s.len)) begin
         r.age = s.age + 9'd1;
      end else if (!s.gap && bbm_of(k)) begin
         r.gap    = 1'b1;
         r.onehot = '0;
      end else begin
         nxt      = (int'(s.line) + 1) % n;
         r.line   = 2'(nxt);
         r.onehot = 4'(1 << nxt);
         r.age    = 9'd0;
         r.len    = {1'b0, dw_i} + 9'd1;
         r.gap    = 1'b0;
         r.wrap   = (nxt == 0);
      end
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) m[k] <= '0;
      end else begin
         for (int k = 0; k < 3; k++) m[k] <= model_step(m[k], k, en, mode, sel, dwell);
      end
   end

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         check($sformatf("u%0d.onehot", k), 32'(act_oh[k]),  32'(m[k].onehot));
         check($sformatf("u%0d.idx", k),    32'(act_idx[k]), 32'(m[k].line));
         check($sformatf("u%0d.wrap", k),   32'(act_wrap[k]), 32'(m[k].wrap));
         check($sformatf("u%0d.multihot", k), 32'($countones(act_oh[k]) <= 1), 32'd1);
      end
   end

   // Outputs settle well before the falling edge; stimulus changes 1 time
   // unit after it so the compare process never races a change.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   int wraps;

   initial begin
      // ---- reset and direct decode
      repeat (2) cyc();
      check("rst onehot", 32'(if0.onehot), 32'h0);
      check("rst idx",    32'(if0.idx),    32'h0);
      check("rst wrap",   32'(if0.wrap),   32'h0);
      rst = 1'b0; en = 1'b1; mode = 1'b0; sel = 2'd3;
      #1;
      check("hold before edge", 32'(if0.onehot), 32'h0);
      cyc();
      check("direct pre", 32'(if0.onehot), 32'h8);
      sel = 2'd1;
      cyc();
      check("direct pre2", 32'(if0.onehot), 32'h2);
      rst = 1'b1;
      #1;
      check("async rst onehot", 32'(if0.onehot), 32'h0);
      check("async rst idx",    32'(if0.idx),    32'h0);
      cyc();
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s);
         cyc();
         check($sformatf("direct sel%0d onehot", s), 32'(if0.onehot), 32'(1 << s));
         check($sformatf("direct sel%0d idx", s),    32'(if0.idx),    32'(s));
      end

      // ---- enable gating
      sel = 2'd2;
      cyc();
      check("gate before", 32'(if0.onehot), 32'h4);
      en = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cyc();
         check($sformatf("gate off %0d onehot", c), 32'(if0.onehot), 32'h0);
         check($sformatf("gate off %0d idx", c),    32'(if0.idx),    32'h2);
      end
      en = 1'b1;
      cyc();
      check("gate on onehot", 32'(if0.onehot), 32'h4);
      check("gate on idx",    32'(if0.idx),    32'h2);

      // ---- scan with dwell=2
      en = 1'b0;
      cyc();
      en = 1'b1; mode = 1'b1; dwell = 8'd2;
      wraps = 0;
      for (int t = 1; t <= 24; t++) begin
         cyc();
         check($sformatf("scan t%0d u0", t), 32'(if0.onehot), 32'(1 << (((t - 1) / 3) % 4)));
         check($sformatf("scan t%0d u0 wrap", t), 32'(if0.wrap), 32'(t == 13));
         check($sformatf("scan t%0d u2", t), 32'(if2.onehot), 32'(1 << (((t - 1) / 3) % 2)));
         if (if0.wrap) wraps++;
      end
      check("scan wrap count", 32'(wraps), 32'd1);

      // ---- break-before-make, dwell=0
      en = 1'b0;
      cyc();
      en = 1'b1; mode = 1'b1; dwell = 8'd0;
      for (int t = 1; t <= 16; t++) begin
         cyc();
         check($sformatf("bbm t%0d", t), 32'(if1.onehot),
               (t % 2 == 1) ? 32'(1 << (((t - 1) / 2) % 4)) : 32'h0);
         check($sformatf("bbm t%0d wrap", t), 32'(if1.wrap), 32'(t == 9));
      end

      // ---- dwell change mid-slot, then switch to direct
      en = 1'b0;
      cyc();
      en = 1'b1; mode = 1'b1; dwell = 8'd3;
      cyc();
      check("dw t1", 32'(if0.onehot), 32'h1);
      dwell = 8'd0;
      for (int t = 2; t <= 4; t++) begin
         cyc();
         check($sformatf("dw t%0d", t), 32'(if0.onehot), 32'h1);
      end
      cyc();
      check("dw t5", 32'(if0.onehot), 32'h2);
      cyc();
      check("dw t6", 32'(if0.onehot), 32'h4);
      mode = 1'b0; sel = 2'd1;
      cyc();
      check("switch onehot", 32'(if0.onehot), 32'h2);
      check("switch idx",    32'(if0.idx),    32'h1);
      check("switch wrap",   32'(if0.wrap),   32'h0);

      // ---- randomized soak
      for (int i = 0; i < 10000; i++) begin
         cyc();
         rst = ($urandom % 1000 == 0);
         en  = ($urandom % 100 != 0);
         if ($urandom % 80 == 0) mode = ~mode;
         sel = 2'($urandom);
         if ($urandom % 25 == 0)
            dwell = ($urandom % 8 == 0) ? 8'($urandom % 40) : 8'($urandom % 4);
      end
      rst = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_scan_decoder
